// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipe_stage_reg family: state codes, per-stage
// bundle widths and the ID/EX field layout with pack/unpack helpers.
package pipe_pkg;

    typedef logic [1:0] state_t;
    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t TWO   = 2'd2;

    // ID/EX control fields, MSB first
    localparam int REG_WRITE_EN_W = 1;
    localparam int MEM2REG_SEL_W  = 1;
    localparam int MEM_WRITE_EN_W = 1;
    localparam int BRANCH_W       = 1;
    localparam int ALU_CTRL_W     = 1;
    localparam int ALU_SRC_W      = 1;
    localparam int REG_DST_SEL_W  = 1;

    localparam int REG_DST_SEL_OFS  = 0;
    localparam int ALU_SRC_OFS      = 1;
    localparam int ALU_CTRL_OFS     = 2;
    localparam int BRANCH_OFS       = 3;
    localparam int MEM_WRITE_EN_OFS = 4;
    localparam int MEM2REG_SEL_OFS  = 5;
    localparam int REG_WRITE_EN_OFS = 6;

    // ID/EX data fields, MSB first
    localparam int REG_DATA_W = 32;
    localparam int PC_ADDR_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SHAMT_W    = 5;
    localparam int IMM_W      = 16;

    localparam int IMM_OFS       = 0;
    localparam int SHAMT_OFS     = 16;
    localparam int RD_ADDR_OFS   = 21;
    localparam int RT_ADDR_OFS   = 26;
    localparam int PC_ADDR_OFS   = 31;
    localparam int REG_DATA2_OFS = 63;
    localparam int REG_DATA1_OFS = 95;

    localparam int IDEX_CTRL_W  = 7;
    localparam int IDEX_DATA_W  = 127;
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 102;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    typedef struct packed {
        logic [REG_WRITE_EN_W-1:0] reg_write_en;
        logic [MEM2REG_SEL_W-1:0]  mem2reg_sel;
        logic [MEM_WRITE_EN_W-1:0] mem_write_en;
        logic [BRANCH_W-1:0]       branch;
        logic [ALU_CTRL_W-1:0]     alu_ctrl;
        logic [ALU_SRC_W-1:0]      alu_src;
        logic [REG_DST_SEL_W-1:0]  reg_dst_sel;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [REG_DATA_W-1:0] reg_data1;
        logic [REG_DATA_W-1:0] reg_data2;
        logic [PC_ADDR_W-1:0]  pc_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [SHAMT_W-1:0]    shamt;
        logic [IMM_W-1:0]      imm;
    } id_ex_data_t;

    function automatic logic [IDEX_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t c);
        return c;
    endfunction

    function automatic id_ex_ctrl_t unpack_id_ex_ctrl(input logic [IDEX_CTRL_W-1:0] v);
        return id_ex_ctrl_t'(v);
    endfunction

    function automatic logic [IDEX_DATA_W-1:0] pack_id_ex_data(input id_ex_data_t d);
        return d;
    endfunction

    function automatic id_ex_data_t unpack_id_ex_data(input logic [IDEX_DATA_W-1:0] v);
        return id_ex_data_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and bundle signals between a pipeline stage register and its
// neighbours; master is the environment, slave is the stage register.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 127
);
    logic              In_Valid;
    logic              In_Ready;
    logic [CTRL_W-1:0] Ctrl_In;
    logic [DATA_W-1:0] Data_In;
    logic              Hold;
    logic              Flush;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [CTRL_W-1:0] Ctrl_Out;
    logic [DATA_W-1:0] Data_Out;

    modport master (
        output In_Valid, Ctrl_In, Data_In, Hold, Flush, Out_Ready,
        input  In_Ready, Out_Valid, Ctrl_Out, Data_Out
    );

    modport slave (
        input  In_Valid, Ctrl_In, Data_In, Hold, Flush, Out_Ready,
        output In_Ready, Out_Valid, Ctrl_Out, Data_Out
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, hazard
// Hold/Flush, bubble gating of control, and an optional 2-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input logic             CLOCK,
    input logic             RESET_N,
    pipe_stage_reg_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              main_load;
    logic              skid_load;
    logic              out_valid;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state != EMPTY);

    // Skid mode derives In_Ready from state alone so it is a clean register output.
    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = (state != TWO);
        end else begin : g_flat_ready
            assign in_ready = !bus.Hold && (!out_valid || bus.Out_Ready);
        end
    endgenerate

    assign in_fire  = bus.In_Valid && in_ready;
    assign out_fire = out_valid && bus.Out_Ready && !bus.Hold;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (bus.Flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && SKID) begin
                        state_nxt = TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        // NOTE: entry registers are reset too, so Data_Out reads 0 straight out of reset.
        if (!RESET_N) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state <= state_nxt;
            if (main_load) begin
                main_ctrl <= (state == TWO) ? skid_ctrl : bus.Ctrl_In;
                main_data <= (state == TWO) ? skid_data : bus.Data_In;
            end
            if (skid_load) begin
                skid_ctrl <= bus.Ctrl_In;
                skid_data <= bus.Data_In;
            end
        end
    end

    // An empty slot is a bubble: control forced to zero, data left as it was.
    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = out_valid;
    assign bus.Ctrl_Out  = out_valid ? main_ctrl : '0;
    assign bus.Data_Out  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance,
// each checked against a FIFO-occupancy model of the stage.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = IDEX_CTRL_W;
    localparam int DW = IDEX_DATA_W;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_s ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_f ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut_skid (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus_s)
    );
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut_flat (
        .CLOCK(clk), .RESET_N(rst_n), .bus(bus_f)
    );

    // index 0 = skid instance, index 1 = single-entry instance
    logic          in_valid  [2] = '{1'b0, 1'b0};
    logic          hold      [2] = '{1'b0, 1'b0};
    logic          flush     [2] = '{1'b0, 1'b0};
    logic          out_ready [2] = '{1'b0, 1'b0};
    logic [CW-1:0] ctrl_in   [2] = '{'0, '0};
    logic [DW-1:0] data_in   [2] = '{'0, '0};
    logic          in_ready  [2];
    logic          out_valid [2];
    logic [CW-1:0] ctrl_out  [2];
    logic [DW-1:0] data_out  [2];

    assign bus_s.In_Valid  = in_valid[0];
    assign bus_s.Hold      = hold[0];
    assign bus_s.Flush     = flush[0];
    assign bus_s.Out_Ready = out_ready[0];
    assign bus_s.Ctrl_In   = ctrl_in[0];
    assign bus_s.Data_In   = data_in[0];
    assign in_ready[0]     = bus_s.In_Ready;
    assign out_valid[0]    = bus_s.Out_Valid;
    assign ctrl_out[0]     = bus_s.Ctrl_Out;
    assign data_out[0]     = bus_s.Data_Out;

    assign bus_f.In_Valid  = in_valid[1];
    assign bus_f.Hold      = hold[1];
    assign bus_f.Flush     = flush[1];
    assign bus_f.Out_Ready = out_ready[1];
    assign bus_f.Ctrl_In   = ctrl_in[1];
    assign bus_f.Data_In   = data_in[1];
    assign in_ready[1]     = bus_f.In_Ready;
    assign out_valid[1]    = bus_f.Out_Valid;
    assign ctrl_out[1]     = bus_f.Ctrl_Out;
    assign data_out[1]     = bus_f.Data_Out;

    int     total = 0;
    int     bad = 0;
    entry_t exp_q [2][$];
    int     occ_now [2] = '{0, 0};
    bit     mon_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_skid(input int d);
        return d == 0;
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        e.ctrl = CW'($urandom());
        e.data = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
        return e;
    endfunction

    // Monitor: the stage behaves as an in-order queue; the head is what must be shown.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                occ_now[d] = exp_q[d].size();
                check($sformatf("out_valid[%0d]", d), DW'(out_valid[d]), DW'(occ_now[d] != 0));
                if (occ_now[d] != 0) begin
                    check($sformatf("ctrl_out[%0d]", d), DW'(ctrl_out[d]), DW'(exp_q[d][0].ctrl));
                    check($sformatf("data_out[%0d]", d), data_out[d], exp_q[d][0].data);
                    if (out_ready[d] && !hold[d]) void'(exp_q[d].pop_front());
                end else begin
                    check($sformatf("bubble_ctrl[%0d]", d), DW'(ctrl_out[d]), '0);
                end
            end
        end
    end

    // One cycle of stimulus; called just after a rising edge.
    task automatic step(input int d, input logic v, input entry_t e, input logic h,
                        input logic f, input logic r, output bit acc);
        bit exp_rdy;
        in_valid[d]  = v;
        ctrl_in[d]   = e.ctrl;
        data_in[d]   = e.data;
        hold[d]      = h;
        flush[d]     = f;
        out_ready[d] = r;
        @(negedge clk);
        #1;
        exp_rdy = is_skid(d) ? (occ_now[d] < 2) : (!h && (occ_now[d] == 0 || r));
        check($sformatf("in_ready[%0d]", d), DW'(in_ready[d]), DW'(exp_rdy));
        acc = v && in_ready[d];
        if (f) exp_q[d].delete();
        else if (acc) exp_q[d].push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        bit acc;
        entry_t z;
        z = '0;
        for (int i = 0; i < n; i++) step(d, 1'b0, z, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic rand_run(input int d, input int n, input bit toggle_only);
        bit     acc;
        bit     pend;
        entry_t e;
        logic   v, h, f, r;
        pend = 1'b0;
        e = '0;
        for (int i = 0; i < n; i++) begin
            if (!pend) e = rand_entry();
            v = pend ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            h = toggle_only ? 1'b0 : 1'($urandom_range(0, 7) == 0);
            f = toggle_only ? 1'b0 : 1'($urandom_range(0, 31) == 0);
            r = toggle_only ? 1'(i % 2) : 1'($urandom_range(0, 3) != 0);
            step(d, v, e, h, f, r, acc);
            pend = v && !acc;
        end
        idle(d, 4);
    endtask

    initial begin
        bit            acc;
        bit            done;
        entry_t        e, ea, eb, ec;
        logic [DW-1:0] exp_main;

        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid[%0d]", d), DW'(out_valid[d]), '0);
            check($sformatf("rst_ctrl[%0d]", d), DW'(ctrl_out[d]), '0);
            check($sformatf("rst_data[%0d]", d), data_out[d], '0);
        end
        #11;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        #1;
        check("rst_in_ready[0]", DW'(in_ready[0]), DW'(1));
        check("rst_in_ready[1]", DW'(in_ready[1]), DW'(1));
        @(posedge clk);
        #1;

        // back-to-back stream of 0..7
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                e.ctrl = CW'($urandom());
                e.data = DW'(i);
                step(d, 1'b1, e, 1'b0, 1'b0, 1'b1, acc);
            end
            idle(d, 3);
        end

        // backpressure fills the skid entry, then drains in order
        ea = rand_entry(); eb = rand_entry(); ec = rand_entry();
        step(0, 1'b1, ea, 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, eb, 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, ec, 1'b0, 1'b0, 1'b0, acc);
        done = 1'b0;
        for (int i = 0; i < 4 && !done; i++) begin
            step(0, 1'b1, ec, 1'b0, 1'b0, 1'b1, acc);
            done = acc;
        end
        check("c_accepted", DW'(done), DW'(1));
        idle(0, 4);

        // flush while full, with D offered
        step(0, 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, acc);
        exp_main = exp_q[0][0].data;
        step(0, 1'b1, rand_entry(), 1'b0, 1'b1, 1'b0, acc);
        step(0, 1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("flush_data_kept", data_out[0], exp_main);
        idle(0, 2);

        // flush with a same-cycle accepted entry that must vanish
        for (int d = 0; d < 2; d++) begin
            step(d, 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, acc);
            step(d, 1'b1, rand_entry(), 1'b0, 1'b1, 1'b1, acc);
            idle(d, 3);
        end

        // hold for 3 cycles with E (ctrl all ones) while F is offered
        for (int d = 0; d < 2; d++) begin
            e = rand_entry();
            e.ctrl = 7'h7F;
            step(d, 1'b1, e, 1'b0, 1'b0, 1'b1, acc);
            ea = rand_entry();
            done = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step(d, !done, ea, 1'b1, 1'b0, 1'b1, acc);
                done = done || acc;
            end
            for (int i = 0; i < 4 && !done; i++) begin
                step(d, 1'b1, ea, 1'b0, 1'b0, 1'b1, acc);
                done = acc;
            end
            check($sformatf("hold_f_accepted[%0d]", d), DW'(done), DW'(1));
            idle(d, 3);
        end

        // single-entry mode with Out_Ready toggling each cycle
        rand_run(1, 30, 1'b1);

        // random traffic with occasional hold and flush
        rand_run(0, 300, 1'b0);
        rand_run(1, 300, 1'b0);

        // asynchronous reset in the middle of a cycle with a valid entry
        step(0, 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, acc);
        in_valid[0] = 1'b0;
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_valid", DW'(out_valid[0]), '0);
        check("async_rst_ctrl", DW'(ctrl_out[0]), '0);
        check("async_rst_data", data_out[0], '0);
        check("async_rst_valid_flat", DW'(out_valid[1]), '0);
        exp_q[0].delete();
        exp_q[1].delete();
        #3;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready[0]", DW'(in_ready[0]), DW'(1));
        check("post_rst_in_ready[1]", DW'(in_ready[1]), DW'(1));
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
